// File: rtl/proc_prog_loader.sv
// Byte-stream program loader: assembles little-endian words, writes them to memory from 0x000
// and holds the processor in reset until the image is in. Optional checksum: PROC_PROG_LOADER_CHECKSUM_EN.
module proc_prog_loader #(
  parameter int unsigned p_max_words = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [7:0]  in_data,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        proc_rst,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W = $clog2(p_max_words + 1);

  typedef enum logic [2:0] {
    ST_CNT_LO = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_DATA   = 3'd2,
`ifdef PROC_PROG_LOADER_CHECKSUM_EN
    ST_CSUM   = 3'd3,
`endif
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  // State entered once the last data byte (or an empty count) has been taken.
`ifdef PROC_PROG_LOADER_CHECKSUM_EN
  localparam state_t ST_TAIL = ST_CSUM;
`else
  localparam state_t ST_TAIL = ST_DONE;
`endif

  state_t             state_q, state_d;
  logic [15:0]        count_q, count_d;
  logic [23:0]        asm_q, asm_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic               in_rdy_q, in_rdy_d;
  logic               mem_wen_q, mem_wen_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               proc_rst_q, proc_rst_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
`ifdef PROC_PROG_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] count_full;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    asm_d       = asm_q;
    byte_cnt_d  = byte_cnt_q;
    word_idx_d  = word_idx_q;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef PROC_PROG_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    accept     = in_val && in_rdy_q;
    count_full = {in_data, count_q[7:0]};

    case (state_q)
      ST_CNT_LO: begin
        if (accept) begin
          count_d[7:0] = in_data;
          state_d      = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (accept) begin
          count_d[15:8] = in_data;
          if (count_full > 16'(p_max_words)) begin
            state_d = ST_ERR;
          end else if (count_full == 16'd0) begin
            state_d = ST_TAIL;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          asm_d      = {in_data, asm_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef PROC_PROG_LOADER_CHECKSUM_EN
          csum_d     = csum_q + in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_wen_d   = 1'b1;
            mem_wdata_d = {in_data, asm_q};
            mem_addr_d  = 32'(word_idx_q) << 2;
            word_idx_d  = word_idx_q + IDX_W'(1);
            if (16'(word_idx_q) == count_q - 16'd1) begin
              state_d = ST_TAIL;
            end
          end
        end
      end
`ifdef PROC_PROG_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: state_d = state_q;
    endcase

    in_rdy_d   = (state_d == ST_CNT_LO) || (state_d == ST_CNT_HI) || (state_d == ST_DATA)
`ifdef PROC_PROG_LOADER_CHECKSUM_EN
                 || (state_d == ST_CSUM)
`endif
                 ;
    // Completion lags DONE entry by a cycle so release follows the final write.
    done_d     = (state_q == ST_DONE);
    proc_rst_d = (state_q != ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CNT_LO;
      count_q     <= '0;
      asm_q       <= '0;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      in_rdy_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      proc_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef PROC_PROG_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      asm_q       <= asm_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      in_rdy_q    <= in_rdy_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      proc_rst_q  <= proc_rst_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef PROC_PROG_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_rdy    = in_rdy_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign proc_rst  = proc_rst_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_proc_prog_loader.sv
// Scoreboard bench for proc_prog_loader: expected writes are queued by the stimulus and
// popped by a monitor on every mem_wen pulse; status outputs are checked at fixed cycles.
module tb_proc_prog_loader;

  logic        clk;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic [7:0]  in_data;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        proc_rst;
  logic        done;
  logic        error;

  proc_prog_loader #(.p_max_words(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .proc_rst  (proc_rst),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          wen_count = 0;
  bit          started   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] img [0:127];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (started && mem_wen === 1'b1) begin
      logic [63:0] e;
      wen_count++;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("mem_addr", mem_addr, e[63:32]);
        check("mem_wdata", mem_wdata, e[31:0]);
      end
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic do_reset();
    rst    = 1'b1;
    in_val = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_proc_rst", proc_rst, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    started = 1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
    in_val = 1'b0;
    repeat (gap) @(negedge clk);
    in_val  = 1'b1;
    in_data = b;
    check("in_rdy_before_byte", in_rdy, 1);
    @(negedge clk);
    in_val = 1'b0;
  endtask

  // Sends count, img[0..n-1] and (checksum build) the byte sum XOR csum_xor.
  task automatic send_image(input int n, input int maxgap, input logic [7:0] csum_xor);
    logic [7:0]  sum;
    logic [31:0] w;
    sum = 8'h00;
    send_byte(n[7:0], maxgap);
    send_byte(n[15:8], maxgap);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      exp_q.push_back({32'(i * 4), w});
      for (int b = 0; b < 4; b++) begin
        sum = sum + w[8*b +: 8];
        send_byte(w[8*b +: 8], maxgap);
      end
    end
`ifdef PROC_PROG_LOADER_CHECKSUM_EN
    send_byte(sum ^ csum_xor, maxgap);
`else
    if (csum_xor != 8'h00) $display("note: checksum corruption ignored in this build");
`endif
  endtask

  // Called right after the final byte is accepted.
  task automatic expect_done(input string tag, input int writes);
    check({tag, "_done_early"}, done, 0);
    check({tag, "_prst_early"}, proc_rst, 1);
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_proc_rst"}, proc_rst, 0);
    check({tag, "_in_rdy"}, in_rdy, 0);
    check({tag, "_error"}, error, 0);
    repeat (2) @(negedge clk);
    check({tag, "_done_sticky"}, done, 1);
    check({tag, "_writes"}, wen_count, writes);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_val = 1'b0; in_data = 8'h00;
    @(negedge clk);

    // Single word, full rate
    do_reset();
    wen_count = 0;
    img[0] = 32'hDEADBEEF;
    send_image(1, 0, 8'h00);
    expect_done("one_word", 1);

    // Three words with random gaps
    do_reset();
    wen_count = 0;
    img[0] = 32'h00000013; img[1] = 32'h12345678; img[2] = 32'hCAFEF00D;
    send_image(3, 3, 8'h00);
    expect_done("three_words", 3);

    // Oversize count
    do_reset();
    wen_count = 0;
    send_byte(8'h81, 0);
    send_byte(8'h00, 0);
    check("big_error", error, 1);
    check("big_proc_rst", proc_rst, 1);
    check("big_in_rdy", in_rdy, 0);
    repeat (3) @(negedge clk);
    check("big_error_sticky", error, 1);
    check("big_done", done, 0);
    check("big_in_rdy_hold", in_rdy, 0);
    check("big_writes", wen_count, 0);

    // Empty image
    do_reset();
    wen_count = 0;
    send_image(0, 0, 8'h00);
    expect_done("empty", 0);

    // Largest accepted image
    do_reset();
    wen_count = 0;
    for (int i = 0; i < 128; i++) begin
      img[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3 + 8'(i)};
    end
    send_image(128, 0, 8'h00);
    expect_done("max", 128);

    // Reset after 6 of 8 data bytes, then reload word 0
    do_reset();
    wen_count = 0;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    exp_q.push_back({32'h0, 32'hA5A5A5A5});
    for (int b = 0; b < 6; b++) send_byte(8'hA5, 0);
    @(negedge clk);
    check("mid_done", done, 0);
    check("mid_proc_rst", proc_rst, 1);
    check("mid_writes", wen_count, 1);
    do_reset();
    wen_count = 0;
    img[0] = 32'h00000013;
    send_image(1, 0, 8'h00);
    expect_done("reload", 1);

`ifdef PROC_PROG_LOADER_CHECKSUM_EN
    // Wrong checksum (0x00 instead of 0xAA), then a correct resend
    do_reset();
    wen_count = 0;
    img[0] = 32'h11223344;
    send_image(1, 0, 8'hAA);
    check("bad_csum_error", error, 1);
    check("bad_csum_proc_rst", proc_rst, 1);
    check("bad_csum_in_rdy", in_rdy, 0);
    repeat (2) @(negedge clk);
    check("bad_csum_done", done, 0);
    check("bad_csum_writes", wen_count, 1);
    do_reset();
    wen_count = 0;
    send_image(1, 0, 8'h00);
    expect_done("good_csum", 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
